fifo_share_ctrl: RTL and testbench

- Controller that shares the write port of one B-bit FIFO between two tick-driven requesters and paces reads out of it.
- Each requester has a 1-deep pending slot; a round-robin arbiter moves pending words into the FIFO, honouring full.
- An optional drain timer issues paced read pulses while the FIFO is non-empty.
- Sits between debounced button ticks and the FIFO instance in board-level test tops.

---
 rtl/fifo_share_ctrl.sv | 106 ++++++++++
 tb/tb_fifo_share_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_share_ctrl.sv
// Shares one FIFO write port between two tick-driven requesters (1-deep slot each,
// round-robin arbitration) and paces FIFO reads with an optional drain timer.
module fifo_share_ctrl #(
    parameter int B   = 3,
    parameter int DIV = 100_000_000,
    parameter int CW  = 8
) (
    input  logic          clk,
    input  logic          CPU_RESETN,
    input  logic          req0_tick,
    input  logic [B-1:0]  data0,
    input  logic          req1_tick,
    input  logic [B-1:0]  data1,
    input  logic          drain_en,
    input  logic          full,
    input  logic          empty,
    output logic          fifo_wr,
    output logic [B-1:0]  fifo_wr_data,
    output logic          fifo_rd,
    output logic [1:0]    pend,
    output logic          last_grant,
    output logic [CW-1:0] drop0,
    output logic [CW-1:0] drop1
);

    localparam int CNT_W = $clog2(DIV);

    logic [B-1:0]     slot0, slot1;
    logic             rr_ptr;
    logic [CNT_W-1:0] cnt;

    logic grant_ok, winner, grant0, grant1, cap0, cap1, lost0, lost1;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        grant_ok = 1'b0;
        winner   = 1'b0;
        grant_ok = !fifo_wr && !full && (pend != 2'b00);
        // A lone pending requester wins outright; with both pending the pointer decides.
        winner   = (pend == 2'b10) || ((pend == 2'b11) && rr_ptr);
        grant0   = grant_ok && !winner;
        grant1   = grant_ok && winner;
        cap0     = req0_tick && (!pend[0] || grant0);
        cap1     = req1_tick && (!pend[1] || grant1);
        lost0    = req0_tick && !cap0;
        lost1    = req1_tick && !cap1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            // NOTE: the slot words are reset too, so a discarded word can never leak into a later write.
            slot0        <= '0;
            slot1        <= '0;
            pend         <= 2'b00;
            rr_ptr       <= 1'b0;
            fifo_wr      <= 1'b0;
            fifo_wr_data <= '0;
            last_grant   <= 1'b0;
            drop0        <= '0;
            drop1        <= '0;
        end else begin
            fifo_wr <= grant_ok;
            if (grant_ok) begin
                fifo_wr_data <= winner ? slot1 : slot0;
                last_grant   <= winner;
                rr_ptr       <= !winner;
            end

            if (cap0) begin
                slot0   <= data0;
                pend[0] <= 1'b1;
            end else if (grant0) begin
                pend[0] <= 1'b0;
            end

            if (cap1) begin
                slot1   <= data1;
                pend[1] <= 1'b1;
            end else if (grant1) begin
                pend[1] <= 1'b0;
            end

            if (lost0 && (drop0 != '1)) drop0 <= drop0 + CW'(1);
            if (lost1 && (drop1 != '1)) drop1 <= drop1 + CW'(1);
        end
    end

    // Drain pacing: one read strobe per DIV cycles, suppressed while the FIFO is empty.
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            cnt     <= '0;
            fifo_rd <= 1'b0;
        end else if (!drain_en) begin
            cnt     <= '0;
            fifo_rd <= 1'b0;
        end else if (cnt == CNT_W'(DIV - 1)) begin
            cnt     <= '0;
            fifo_rd <= !empty;
        end else begin
            cnt     <= cnt + CNT_W'(1);
            fifo_rd <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Directed bench for fifo_share_ctrl: a vector table for arbitration/capture/drop
// behaviour plus hand sequences for drop saturation, drain pacing and async reset.
module tb_fifo_share_ctrl;

    localparam int B   = 3;
    localparam int DIV = 4;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          CPU_RESETN;
    logic          req0_tick, req1_tick, drain_en, full, empty;
    logic [B-1:0]  data0, data1;
    logic          fifo_wr, fifo_rd, last_grant;
    logic [B-1:0]  fifo_wr_data;
    logic [1:0]    pend;
    logic [CW-1:0] drop0, drop1;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    fifo_share_ctrl #(.B(B), .DIV(DIV), .CW(CW)) dut (
        .clk(clk), .CPU_RESETN(CPU_RESETN),
        .req0_tick(req0_tick), .data0(data0),
        .req1_tick(req1_tick), .data1(data1),
        .drain_en(drain_en), .full(full), .empty(empty),
        .fifo_wr(fifo_wr), .fifo_wr_data(fifo_wr_data), .fifo_rd(fifo_rd),
        .pend(pend), .last_grant(last_grant), .drop0(drop0), .drop1(drop1)
    );

    typedef struct packed {
        logic          wr;
        logic [B-1:0]  wd;
        logic          rd;
        logic [1:0]    pend;
        logic          lg;
        logic [CW-1:0] d0;
        logic [CW-1:0] d1;
    } outs_t;

    typedef struct packed {
        logic         r0;
        logic [B-1:0] a;
        logic         r1;
        logic [B-1:0] b;
        logic         f;
        outs_t        exp;
    } vec_t;

    vec_t tbl [26];

    function automatic outs_t o(input logic wr, input logic [B-1:0] wd, input logic rd,
                                input logic [1:0] p, input logic lg, input int d0, input int d1);
        outs_t r;
        r = '{wr: wr, wd: wd, rd: rd, pend: p, lg: lg, d0: CW'(d0), d1: CW'(d1)};
        return r;
    endfunction

    function automatic vec_t v(input logic r0, input logic [B-1:0] a, input logic r1,
                               input logic [B-1:0] b, input logic f, input logic wr,
                               input logic [B-1:0] wd, input logic [1:0] p, input logic lg,
                               input int d0, input int d1);
        vec_t r;
        r = '{r0: r0, a: a, r1: r1, b: b, f: f, exp: o(wr, wd, 1'b0, p, lg, d0, d1)};
        return r;
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t got;
        got = '{wr: fifo_wr, wd: fifo_wr_data, rd: fifo_rd, pend: pend, lg: last_grant,
                d0: drop0, d1: drop1};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got wr=%b wd=%b rd=%b pend=%b lg=%b d0=%0d d1=%0d, want wr=%b wd=%b rd=%b pend=%b lg=%b d0=%0d d1=%0d",
                     name, got.wr, got.wd, got.rd, got.pend, got.lg, got.d0, got.d1,
                     exp.wr, exp.wd, exp.rd, exp.pend, exp.lg, exp.d0, exp.d1);
        end
    endtask

    // Drive one cycle of requester/full inputs at the falling edge, then sample just after the rising edge.
    task automatic step(input logic r0, input logic [B-1:0] a, input logic r1,
                        input logic [B-1:0] b, input logic f);
        @(negedge clk);
        req0_tick = r0; data0 = a; req1_tick = r1; data1 = b; full = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        CPU_RESETN = 1'b0;
        req0_tick = 1'b0; req1_tick = 1'b0; data0 = '0; data1 = '0;
        drain_en = 1'b0; full = 1'b0; empty = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("reset", o(0, 3'b000, 0, 2'b00, 0, 0, 0));
        @(negedge clk);
        CPU_RESETN = 1'b1;

        for (int i = 0; i < 20; i++) begin
            step(0, 3'b000, 0, 3'b000, 0);
            check($sformatf("idle%0d", i), o(0, 3'b000, 0, 2'b00, 0, 0, 0));
        end

        //        r0 a       r1 b       f   wr wd      pend   lg d0 d1
        tbl[0]  = v(1, 3'b001, 1, 3'b110, 0,  0, 3'b000, 2'b11, 0, 0, 0);
        tbl[1]  = v(0, 3'b000, 0, 3'b000, 0,  1, 3'b001, 2'b10, 0, 0, 0);
        tbl[2]  = v(0, 3'b000, 0, 3'b000, 0,  0, 3'b001, 2'b10, 0, 0, 0);
        tbl[3]  = v(0, 3'b000, 0, 3'b000, 0,  1, 3'b110, 2'b00, 1, 0, 0);
        tbl[4]  = v(0, 3'b000, 0, 3'b000, 0,  0, 3'b110, 2'b00, 1, 0, 0);
        tbl[5]  = v(1, 3'b101, 0, 3'b000, 0,  0, 3'b110, 2'b01, 1, 0, 0);
        tbl[6]  = v(0, 3'b000, 0, 3'b000, 0,  1, 3'b101, 2'b00, 0, 0, 0);
        tbl[7]  = v(0, 3'b000, 0, 3'b000, 0,  0, 3'b101, 2'b00, 0, 0, 0);
        tbl[8]  = v(0, 3'b000, 1, 3'b010, 1,  0, 3'b101, 2'b10, 0, 0, 0);
        tbl[9]  = v(0, 3'b000, 1, 3'b011, 1,  0, 3'b101, 2'b10, 0, 0, 1);
        tbl[10] = v(0, 3'b000, 1, 3'b100, 1,  0, 3'b101, 2'b10, 0, 0, 2);
        tbl[11] = v(0, 3'b000, 0, 3'b000, 1,  0, 3'b101, 2'b10, 0, 0, 2);
        tbl[12] = v(0, 3'b000, 0, 3'b000, 0,  1, 3'b010, 2'b00, 1, 0, 2);
        tbl[13] = v(0, 3'b000, 0, 3'b000, 0,  0, 3'b010, 2'b00, 1, 0, 2);
        tbl[14] = v(1, 3'b011, 0, 3'b000, 0,  0, 3'b010, 2'b01, 1, 0, 2);
        tbl[15] = v(1, 3'b111, 0, 3'b000, 0,  1, 3'b011, 2'b01, 0, 0, 2);
        tbl[16] = v(0, 3'b000, 0, 3'b000, 0,  0, 3'b011, 2'b01, 0, 0, 2);
        tbl[17] = v(0, 3'b000, 0, 3'b000, 0,  1, 3'b111, 2'b00, 0, 0, 2);
        tbl[18] = v(0, 3'b000, 0, 3'b000, 0,  0, 3'b111, 2'b00, 0, 0, 2);
        tbl[19] = v(1, 3'b000, 0, 3'b000, 0,  0, 3'b111, 2'b01, 0, 0, 2);
        tbl[20] = v(1, 3'b001, 0, 3'b000, 1,  0, 3'b111, 2'b01, 0, 1, 2);
        tbl[21] = v(0, 3'b000, 0, 3'b000, 0,  1, 3'b000, 2'b00, 0, 1, 2);
        tbl[22] = v(1, 3'b010, 1, 3'b101, 0,  0, 3'b000, 2'b11, 0, 1, 2);
        tbl[23] = v(0, 3'b000, 0, 3'b000, 0,  1, 3'b101, 2'b01, 1, 1, 2);
        tbl[24] = v(0, 3'b000, 0, 3'b000, 0,  0, 3'b101, 2'b01, 1, 1, 2);
        tbl[25] = v(0, 3'b000, 0, 3'b000, 0,  1, 3'b010, 2'b00, 0, 1, 2);

        for (int i = 0; i < 26; i++) begin
            step(tbl[i].r0, tbl[i].a, tbl[i].r1, tbl[i].b, tbl[i].f);
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Drop counter saturates at 2^CW-1 while full holds the slot.
        step(1, 3'b011, 0, 3'b000, 1);
        check("sat_capture", o(0, 3'b010, 0, 2'b01, 0, 1, 2));
        for (int i = 0; i < 9; i++) step(1, 3'b110, 0, 3'b000, 1);
        check("sat_drop0", o(0, 3'b010, 0, 2'b01, 0, 7, 2));
        step(0, 3'b000, 0, 3'b000, 0);
        check("sat_release", o(1, 3'b011, 0, 2'b00, 0, 7, 2));
        step(0, 3'b000, 0, 3'b000, 0);
        check("sat_idle", o(0, 3'b011, 0, 2'b00, 0, 7, 2));

        // Drain pacing with DIV=4: pulse after every 4th edge while non-empty.
        @(negedge clk);
        drain_en = 1'b1; empty = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check($sformatf("drain%0d", k), o(0, 3'b011, (k % 4) == 3, 2'b00, 0, 7, 2));
        end
        @(negedge clk);
        empty = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            check($sformatf("drain_empty%0d", k), o(0, 3'b011, 0, 2'b00, 0, 7, 2));
        end
        @(negedge clk);
        empty = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("drain_phase%0d", k), o(0, 3'b011, k == 3, 2'b00, 0, 7, 2));
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check($sformatf("drain_mid%0d", k), o(0, 3'b011, 0, 2'b00, 0, 7, 2));
        end
        @(negedge clk);
        drain_en = 1'b0;
        @(posedge clk); #1;
        check("drain_off", o(0, 3'b011, 0, 2'b00, 0, 7, 2));
        @(negedge clk);
        drain_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("drain_restart%0d", k), o(0, 3'b011, k == 3, 2'b00, 0, 7, 2));
        end
        @(negedge clk);
        drain_en = 1'b0; empty = 1'b1;

        // Async reset with both slots pending and a write strobe in flight.
        step(1, 3'b011, 1, 3'b100, 0);
        check("rst_pre_fill", o(0, 3'b011, 0, 2'b11, 0, 7, 2));
        step(0, 3'b000, 1, 3'b101, 0);
        check("rst_pre_wr", o(1, 3'b100, 0, 2'b11, 1, 7, 2));
        req0_tick = 1'b0; req1_tick = 1'b0;
        #2;
        CPU_RESETN = 1'b0;
        #1;
        check("rst_async", o(0, 3'b000, 0, 2'b00, 0, 0, 0));
        @(negedge clk);
        CPU_RESETN = 1'b1;
        step(1, 3'b101, 1, 3'b010, 0);
        check("rst_refill", o(0, 3'b000, 0, 2'b11, 0, 0, 0));
        step(0, 3'b000, 0, 3'b000, 0);
        check("rst_first_grant", o(1, 3'b101, 0, 2'b10, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
